// File: rtl/mips_defs.sv
// Shared MIPS definitions for the MEM-stage load/store unit: aluop codes,
// address-error exception codes and the LSU FSM state encoding.
package mips_defs;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ALUOP_W = 8;
    localparam int unsigned EXC_W   = 5;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned LANE_W  = 4;

    localparam logic [ALUOP_W-1:0] OP_LB  = 8'h90;
    localparam logic [ALUOP_W-1:0] OP_LBU = 8'h91;
    localparam logic [ALUOP_W-1:0] OP_LH  = 8'h92;
    localparam logic [ALUOP_W-1:0] OP_LHU = 8'h93;
    localparam logic [ALUOP_W-1:0] OP_LW  = 8'h94;
    localparam logic [ALUOP_W-1:0] OP_SB  = 8'h98;
    localparam logic [ALUOP_W-1:0] OP_SH  = 8'h99;
    localparam logic [ALUOP_W-1:0] OP_SW  = 8'h9A;

    localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'h05;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_bytesel.sv
// Opcode decode for the LSU: lane mask, store data replication and misalign flag.
module lsu_bytesel
    import mips_defs::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  logic [DATA_W-1:0]  din,
    output logic               is_mem,
    output logic               is_load,
    output logic               is_store,
    output logic [LANE_W-1:0]  lane_mask,
    output logic [DATA_W-1:0]  wdata,
    output logic               misalign
);

    logic [LANE_W-1:0] byte_mask;
    logic [LANE_W-1:0] half_mask;

    assign byte_mask = 4'b0001 << addr_lo;
    assign half_mask = 4'b0011 << {addr_lo[1], 1'b0};

    always_comb begin
        is_mem    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        lane_mask = '0;
        wdata     = din;
        misalign  = 1'b0;
        unique case (aluop)
            OP_LB, OP_LBU: begin
                is_load   = 1'b1;
                lane_mask = byte_mask;
            end
            OP_LH, OP_LHU: begin
                is_load   = 1'b1;
                lane_mask = half_mask;
                misalign  = addr_lo[0];
            end
            OP_LW: begin
                is_load   = 1'b1;
                lane_mask = 4'b1111;
                misalign  = (addr_lo != 2'b00);
            end
            OP_SB: begin
                is_store  = 1'b1;
                lane_mask = byte_mask;
                wdata     = {4{din[7:0]}};
            end
            OP_SH: begin
                is_store  = 1'b1;
                lane_mask = half_mask;
                wdata     = {2{din[15:0]}};
                misalign  = addr_lo[0];
            end
            OP_SW: begin
                is_store  = 1'b1;
                lane_mask = 4'b1111;
                misalign  = (addr_lo != 2'b00);
            end
            default: ;
        endcase
        is_mem = is_load | is_store;
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives the data-memory request bus and MEM/WB fields.
// Optional misaligned-address exceptions are enabled by MEM_UNALIGNED_EXC_EN.
module mem_lsu
    import mips_defs::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [ALUOP_W-1:0]  mem_aluop,
    input  logic [DATA_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_din,
    input  logic [REG_W-1:0]    mem_wa,
    input  logic                mem_wreg,
    input  logic                flush,
    output logic                dm_req,
    output logic [LANE_W-1:0]   dm_we,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    input  logic                dm_gnt,
    input  logic                dm_rvalid,
    input  logic [DATA_W-1:0]   dm_rdata,
    output logic [DATA_W-1:0]   out_dreg,
    output logic [REG_W-1:0]    out_wa,
    output logic                out_wreg,
    output logic                out_mreg,
    output logic [LANE_W-1:0]   out_dre,
    output logic                stall_req,
    output logic                exc_valid,
    output logic [EXC_W-1:0]    exc_code,
    output logic [DATA_W-1:0]   exc_badvaddr
);

    lsu_state_e        state_q, state_d;
    logic              sel_mem, sel_load, sel_store, misalign;
    logic              is_mem, is_load, is_store, mis_exc;
    logic [LANE_W-1:0] lane_mask;
    logic [DATA_W-1:0] st_wdata;

    lsu_bytesel u_bytesel (
        .aluop     (mem_aluop),
        .addr_lo   (mem_addr[1:0]),
        .din       (mem_din),
        .is_mem    (sel_mem),
        .is_load   (sel_load),
        .is_store  (sel_store),
        .lane_mask (lane_mask),
        .wdata     (st_wdata),
        .misalign  (misalign)
    );

    assign is_mem   = in_valid & sel_mem;
    assign is_load  = in_valid & sel_load;
    assign is_store = in_valid & sel_store;

`ifdef MEM_UNALIGNED_EXC_EN
    assign mis_exc = is_mem & misalign;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign mis_exc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Non-memory passthrough is the default; each state overrides for the op in flight.
    always_comb begin
        state_d      = state_q;
        out_dreg     = mem_addr;
        out_wa       = mem_wa;
        out_wreg     = mem_wreg;
        out_mreg     = 1'b0;
        out_dre      = '0;
        dm_req       = 1'b0;
        stall_req    = 1'b0;
        exc_valid    = 1'b0;
        exc_code     = '0;
        exc_badvaddr = '0;

        if (is_load) begin
            out_dreg = dm_rdata;
            out_mreg = 1'b1;
            out_dre  = lane_mask;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (is_mem) begin
                    out_wreg = 1'b0;
                    if (mis_exc) begin
                        exc_valid    = 1'b1;
                        exc_code     = is_load ? EXC_ADEL : EXC_ADES;
                        exc_badvaddr = mem_addr;
                    end else if (!flush) begin
                        dm_req = 1'b1;
                        if (!dm_gnt) begin
                            state_d   = ST_REQ;
                            stall_req = 1'b1;
                        end else if (is_load) begin
                            state_d   = ST_WAIT;
                            stall_req = 1'b1;
                        end else begin
                            out_wreg = mem_wreg;
                        end
                    end
                end
            end
            ST_REQ: begin
                out_wreg = 1'b0;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    dm_req    = 1'b1;
                    stall_req = 1'b1;
                    if (dm_gnt) begin
                        if (is_load) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d   = ST_IDLE;
                            stall_req = 1'b0;
                            out_wreg  = mem_wreg;
                        end
                    end
                end
            end
            ST_WAIT: begin
                out_wreg = 1'b0;
                if (flush) begin
                    state_d = dm_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (dm_rvalid) begin
                    state_d  = ST_IDLE;
                    out_wreg = mem_wreg;
                end else begin
                    stall_req = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dm_rvalid) begin
                    state_d = ST_IDLE;
                end
                // A new memory op may not issue until the abandoned read returns.
                if (is_mem) begin
                    stall_req = 1'b1;
                    out_wreg  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            out_wreg     = 1'b0;
            exc_valid    = 1'b0;
            exc_code     = '0;
            exc_badvaddr = '0;
        end

        if (rst) begin
            out_dreg     = '0;
            out_wa       = '0;
            out_wreg     = 1'b0;
            out_mreg     = 1'b0;
            out_dre      = '0;
            dm_req       = 1'b0;
            stall_req    = 1'b0;
            exc_valid    = 1'b0;
            exc_code     = '0;
            exc_badvaddr = '0;
        end
    end

    // Bus fields are only driven while a request is presented.
    always_comb begin
        dm_addr  = '0;
        dm_we    = '0;
        dm_wdata = '0;
        if (dm_req) begin
            dm_addr = {mem_addr[ADDR_W-1:2], 2'b00};
            if (is_store) begin
                dm_we    = lane_mask;
                dm_wdata = st_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu; honours MEM_UNALIGNED_EXC_EN if defined.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [4:0]  mem_wa;
    logic        mem_wreg;
    logic        flush;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [31:0] out_dreg;
    logic [4:0]  out_wa;
    logic        out_wreg;
    logic        out_mreg;
    logic [3:0]  out_dre;
    logic        stall_req;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;

    int vectors     = 0;
    int miscompares = 0;

    mem_lsu #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .mem_aluop    (mem_aluop),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_wa       (mem_wa),
        .mem_wreg     (mem_wreg),
        .flush        (flush),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_gnt       (dm_gnt),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata),
        .out_dreg     (out_dreg),
        .out_wa       (out_wa),
        .out_wreg     (out_wreg),
        .out_mreg     (out_mreg),
        .out_dre      (out_dre),
        .stall_req    (stall_req),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_badvaddr (exc_badvaddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one MEM-stage op plus bus responses, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic wr, input logic g,
                         input logic rv, input logic [31:0] rd, input logic fl);
        in_valid  = v;
        mem_aluop = op;
        mem_addr  = a;
        mem_din   = d;
        mem_wa    = 5'd7;
        mem_wreg  = wr;
        dm_gnt    = g;
        dm_rvalid = rv;
        dm_rdata  = rd;
        flush     = fl;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        // Reset forces every output low even with a load presented.
        drive(1, 8'h94, 32'h100, 32'h0, 1, 1, 0, 32'h0, 0);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_out_wreg", 32'(out_wreg), 32'd0);
        chk("rst_out_mreg", 32'(out_mreg), 32'd0);
        chk("rst_out_dre", 32'(out_dre), 32'd0);
        chk("rst_out_dreg", out_dreg, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        tick();
        rst = 1'b0;

        // ADDU passthrough.
        drive(1, 8'h21, 32'h5, 32'h0, 1, 0, 0, 32'h0, 0);
        chk("addu_dreg", out_dreg, 32'h5);
        chk("addu_wreg", 32'(out_wreg), 32'd1);
        chk("addu_wa", 32'(out_wa), 32'd7);
        chk("addu_stall", 32'(stall_req), 32'd0);
        chk("addu_req", 32'(dm_req), 32'd0);
        chk("addu_mreg", 32'(out_mreg), 32'd0);
        tick();

        // LW granted immediately, data next cycle.
        drive(1, 8'h94, 32'h100, 32'h0, 1, 1, 0, 32'h0, 0);
        chk("lw_c1_req", 32'(dm_req), 32'd1);
        chk("lw_c1_addr", dm_addr, 32'h100);
        chk("lw_c1_we", 32'(dm_we), 32'd0);
        chk("lw_c1_stall", 32'(stall_req), 32'd1);
        chk("lw_c1_wreg", 32'(out_wreg), 32'd0);
        tick();
        drive(1, 8'h94, 32'h100, 32'h0, 1, 0, 1, 32'hDEADBEEF, 0);
        chk("lw_c2_req", 32'(dm_req), 32'd0);
        chk("lw_c2_stall", 32'(stall_req), 32'd0);
        chk("lw_c2_dreg", out_dreg, 32'hDEADBEEF);
        chk("lw_c2_dre", 32'(out_dre), 32'hF);
        chk("lw_c2_wreg", 32'(out_wreg), 32'd1);
        chk("lw_c2_mreg", 32'(out_mreg), 32'd1);
        tick();

        // SB with grant delayed three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h98, 32'h103, 32'h000000AB, 0, 0, 0, 32'h0, 0);
            chk("sb_wait_req", 32'(dm_req), 32'd1);
            chk("sb_wait_we", 32'(dm_we), 32'h8);
            chk("sb_wait_wdata", dm_wdata, 32'hABABABAB);
            chk("sb_wait_addr", dm_addr, 32'h100);
            chk("sb_wait_stall", 32'(stall_req), 32'd1);
            tick();
        end
        drive(1, 8'h98, 32'h103, 32'h000000AB, 0, 1, 0, 32'h0, 0);
        chk("sb_gnt_req", 32'(dm_req), 32'd1);
        chk("sb_gnt_we", 32'(dm_we), 32'h8);
        chk("sb_gnt_stall", 32'(stall_req), 32'd0);
        tick();

        // SH upper half, granted at once.
        drive(1, 8'h99, 32'h102, 32'h00001234, 0, 1, 0, 32'h0, 0);
        chk("sh_we", 32'(dm_we), 32'hC);
        chk("sh_wdata", dm_wdata, 32'h12341234);
        chk("sh_stall", 32'(stall_req), 32'd0);
        tick();

        // LH at odd address.
        drive(1, 8'h92, 32'h101, 32'h0, 1, 1, 0, 32'h0, 0);
`ifdef MEM_UNALIGNED_EXC_EN
        chk("lh_mis_exc", 32'(exc_valid), 32'd1);
        chk("lh_mis_code", 32'(exc_code), 32'h04);
        chk("lh_mis_bad", exc_badvaddr, 32'h101);
        chk("lh_mis_req", 32'(dm_req), 32'd0);
        chk("lh_mis_stall", 32'(stall_req), 32'd0);
        chk("lh_mis_wreg", 32'(out_wreg), 32'd0);
        tick();
`else
        chk("lh_mis_exc", 32'(exc_valid), 32'd0);
        chk("lh_mis_req", 32'(dm_req), 32'd1);
        chk("lh_mis_addr", dm_addr, 32'h100);
        chk("lh_mis_dre", 32'(out_dre), 32'h3);
        tick();
        drive(1, 8'h92, 32'h101, 32'h0, 1, 0, 1, 32'h0000CAFE, 0);
        chk("lh_mis_done", 32'(out_wreg), 32'd1);
        tick();
`endif

        // LW flushed while waiting; following LW blocked until the drain completes.
        drive(1, 8'h94, 32'h200, 32'h0, 1, 1, 0, 32'h0, 0);
        tick();
        drive(1, 8'h94, 32'h200, 32'h0, 1, 0, 0, 32'h0, 1);
        chk("fl_wait_req", 32'(dm_req), 32'd0);
        chk("fl_wait_wreg", 32'(out_wreg), 32'd0);
        tick();
        drive(1, 8'h94, 32'h300, 32'h0, 1, 1, 0, 32'h0, 0);
        chk("drain_req", 32'(dm_req), 32'd0);
        chk("drain_stall", 32'(stall_req), 32'd1);
        chk("drain_wreg", 32'(out_wreg), 32'd0);
        tick();
        drive(1, 8'h94, 32'h300, 32'h0, 1, 1, 1, 32'h11111111, 0);
        chk("drain_rv_req", 32'(dm_req), 32'd0);
        chk("drain_rv_stall", 32'(stall_req), 32'd1);
        chk("drain_rv_wreg", 32'(out_wreg), 32'd0);
        tick();
        drive(1, 8'h94, 32'h300, 32'h0, 1, 1, 0, 32'h0, 0);
        chk("post_drain_req", 32'(dm_req), 32'd1);
        chk("post_drain_addr", dm_addr, 32'h300);
        tick();
        drive(1, 8'h94, 32'h300, 32'h0, 1, 0, 1, 32'h22222222, 0);
        chk("post_drain_dreg", out_dreg, 32'h22222222);
        chk("post_drain_wreg", 32'(out_wreg), 32'd1);
        tick();

        // Reset while in REQ; stale rvalid afterwards must be ignored.
        drive(1, 8'h94, 32'h400, 32'h0, 1, 0, 0, 32'h0, 0);
        chk("rq_req", 32'(dm_req), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rq_rst_req", 32'(dm_req), 32'd0);
        tick();
        rst = 1'b0;
        drive(1, 8'h94, 32'h500, 32'h0, 1, 0, 1, 32'h33333333, 0);
        chk("stale_req", 32'(dm_req), 32'd1);
        chk("stale_addr", dm_addr, 32'h500);
        chk("stale_wreg", 32'(out_wreg), 32'd0);
        chk("stale_stall", 32'(stall_req), 32'd1);
        tick();
        drive(1, 8'h94, 32'h500, 32'h0, 1, 1, 0, 32'h0, 0);
        chk("stale_gnt_stall", 32'(stall_req), 32'd1);
        tick();
        drive(1, 8'h94, 32'h500, 32'h0, 1, 0, 1, 32'h5A5A5A5A, 0);
        chk("stale_done_dreg", out_dreg, 32'h5A5A5A5A);
        chk("stale_done_wreg", 32'(out_wreg), 32'd1);
        tick();

        // Flush withdraws an ungranted store.
        drive(1, 8'h9A, 32'h600, 32'h77, 0, 0, 0, 32'h0, 0);
        chk("sw_req_we", 32'(dm_we), 32'hF);
        chk("sw_req_wdata", dm_wdata, 32'h77);
        tick();
        drive(1, 8'h9A, 32'h600, 32'h77, 0, 0, 0, 32'h0, 1);
        chk("sw_fl_req", 32'(dm_req), 32'd0);
        chk("sw_fl_we", 32'(dm_we), 32'd0);
        tick();
        drive(1, 8'h21, 32'h9, 32'h0, 1, 0, 0, 32'h0, 0);
        chk("after_fl_req", 32'(dm_req), 32'd0);
        chk("after_fl_dreg", out_dreg, 32'h9);
        chk("after_fl_wreg", 32'(out_wreg), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
